// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, receive FIFO depth and byte type.
package uart_pkg;

   localparam int unsigned UART_DATA_W   = 8;
   localparam int unsigned RX_FIFO_DEPTH = 16;

   typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/rise_edge_det.sv
// Rising-edge detector for a level input; register resets high so a level
// already asserted when reset releases is not reported as an edge.
module rise_edge_det (
   input  logic clk_i,
   input  logic rst_i,
   input  logic level_i,
   output logic rise_o
);

   logic prev_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prev_q <= 1'b1;
      end else begin
         prev_q <= level_i;
      end
   end

   assign rise_o = level_i & ~prev_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte FIFO: captures one byte per rising edge of the
// UART data-ready level, exposes head/occupancy and sticky error flags.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH  = RX_FIFO_DEPTH,
   parameter int unsigned DATA_W = UART_DATA_W
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     rx_pulse_i,
   input  logic [DATA_W-1:0]        rx_data_i,
   input  logic                     pop_i,
   input  logic                     clr_i,
   output logic [DATA_W-1:0]        data_o,
   output logic                     empty_o,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     new_rx_o,
   output logic                     overflow_o,
   output logic                     underflow_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [CW-1:0]     count_q;
   logic              new_rx_q;
   logic              overflow_q;
   logic              underflow_q;

   logic rise;
   logic empty;
   logic full;
   logic push_ok;
   logic pop_ok;

   rise_edge_det u_rise (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .level_i (rx_pulse_i),
      .rise_o  (rise)
   );

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));

   // A pop on a full FIFO frees the slot the coincident push needs.
   assign pop_ok  = pop_i & ~empty;
   assign push_ok = rise & (~full | pop_i);

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         new_rx_q    <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         new_rx_q <= push_ok;
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
         if (rise && full && !pop_i) begin
            overflow_q <= 1'b1;
         end
         if (pop_i && empty) begin
            underflow_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && !clr_i && push_ok) begin
         mem[wr_ptr_q] <= rx_data_i;
      end
   end

   assign data_o      = empty ? '0 : mem[rd_ptr_q];
   assign empty_o     = empty;
   assign full_o      = full;
   assign count_o     = count_q;
   assign new_rx_o    = new_rx_q;
   assign overflow_o  = overflow_q;
   assign underflow_o = underflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_uart_rx_fifo;

   localparam int unsigned DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst_i;
   logic       rx_pulse_i;
   logic [7:0] rx_data_i;
   logic       pop_i;
   logic       clr_i;
   logic [7:0] data_o;
   logic       empty_o;
   logic       full_o;
   logic [4:0] count_o;
   logic       new_rx_o;
   logic       overflow_o;
   logic       underflow_o;

   always #5 clk = ~clk;

   uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(8)) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .rx_pulse_i  (rx_pulse_i),
      .rx_data_i   (rx_data_i),
      .pop_i       (pop_i),
      .clr_i       (clr_i),
      .data_o      (data_o),
      .empty_o     (empty_o),
      .full_o      (full_o),
      .count_o     (count_o),
      .new_rx_o    (new_rx_o),
      .overflow_o  (overflow_o),
      .underflow_o (underflow_o)
   );

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // Reference model state
   byte unsigned m_q[$];
   bit           m_prev = 1'b1;
   bit           m_new  = 1'b0;
   bit           m_ovf  = 1'b0;
   bit           m_udf  = 1'b0;

   task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
      end
   endtask

   task automatic model_step();
      bit rise;
      bit was_empty;
      bit was_full;
      if (rst_i) begin
         m_q.delete();
         m_prev = 1'b1;
         m_new  = 1'b0;
         m_ovf  = 1'b0;
         m_udf  = 1'b0;
         return;
      end
      rise   = rx_pulse_i && !m_prev;
      m_prev = rx_pulse_i;
      m_new  = 1'b0;
      if (clr_i) begin
         m_q.delete();
         m_ovf = 1'b0;
         m_udf = 1'b0;
         return;
      end
      was_empty = (m_q.size() == 0);
      was_full  = (m_q.size() == DEPTH);
      if (pop_i && was_empty) m_udf = 1'b1;
      if (pop_i && !was_empty) void'(m_q.pop_front());
      if (rise) begin
         if (was_full && !pop_i) begin
            m_ovf = 1'b1;
         end else begin
            m_q.push_back(rx_data_i);
            m_new = 1'b1;
         end
      end
   endtask

   task automatic check_all();
      check_eq("count",     count_o,     m_q.size());
      check_eq("empty",     empty_o,     m_q.size() == 0);
      check_eq("full",      full_o,      m_q.size() == DEPTH);
      check_eq("data",      data_o,      (m_q.size() == 0) ? 0 : m_q[0]);
      check_eq("new_rx",    new_rx_o,    m_new);
      check_eq("overflow",  overflow_o,  m_ovf);
      check_eq("underflow", underflow_o, m_udf);
   endtask

   task automatic cyc(input bit rst, input bit p, input byte unsigned d, input bit po, input bit c);
      @(negedge clk);
      rst_i      = rst;
      rx_pulse_i = p;
      rx_data_i  = d;
      pop_i      = po;
      clr_i      = c;
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic push_byte(input byte unsigned b);
      cyc(0, 1, b, 0, 0);
      cyc(0, 0, b, 0, 0);
   endtask

   initial begin
      rst_i = 1'b1; rx_pulse_i = 1'b1; rx_data_i = 8'h99; pop_i = 1'b0; clr_i = 1'b0;

      // Level held high across reset release is not captured
      repeat (3) cyc(1, 1, 8'h99, 0, 0);
      repeat (3) cyc(0, 1, 8'h99, 0, 0);
      check_eq("held_no_push", count_o, 0);
      cyc(0, 0, 8'h00, 0, 0);

      // Long pulse yields exactly one entry
      repeat (3) cyc(0, 1, 8'h41, 0, 0);
      check_eq("long_pulse_data", data_o, 8'h41);
      cyc(0, 0, 8'h41, 0, 0);
      cyc(0, 0, 8'h00, 1, 0);
      check_eq("pop_to_empty", data_o, 0);

      // Fill, overflow, drain in order
      for (int i = 0; i < 16; i++) push_byte(byte'(i));
      check_eq("fill_full", full_o, 1);
      push_byte(8'hAA);
      check_eq("ovf_set", overflow_o, 1);
      for (int i = 0; i < 16; i++) begin
         check_eq("drain_seq", data_o, i);
         cyc(0, 0, 8'h00, 1, 0);
      end
      check_eq("ovf_sticky", overflow_o, 1);
      cyc(0, 0, 8'h00, 0, 1);

      // Push and pop together on a full FIFO; pointer wrap
      for (int i = 0; i < 16; i++) push_byte(byte'($urandom));
      cyc(0, 1, 8'h55, 1, 0);
      check_eq("full_pp_count", count_o, 16);
      check_eq("full_pp_ovf", overflow_o, 0);
      cyc(0, 0, 8'h00, 0, 0);
      for (int i = 0; i < 15; i++) cyc(0, 0, 8'h00, 1, 0);
      check_eq("wrap_last", data_o, 8'h55);
      cyc(0, 0, 8'h00, 1, 0);

      // Pop with push on empty FIFO
      cyc(0, 1, 8'h7E, 1, 0);
      check_eq("empty_pp_data", data_o, 8'h7E);
      check_eq("empty_pp_udf", underflow_o, 1);
      cyc(0, 0, 8'h00, 0, 1);

      // Clear beats coincident push
      for (int i = 0; i < 5; i++) push_byte(byte'($urandom));
      cyc(0, 1, 8'h33, 0, 1);
      check_eq("clr_count", count_o, 0);
      cyc(0, 0, 8'h00, 0, 0);
      push_byte(8'h34);
      check_eq("after_clr_data", data_o, 8'h34);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         bit r  = ($urandom_range(0, 299) == 0);
         bit c  = ($urandom_range(0, 99) == 0);
         bit p  = ($urandom_range(0, 2) != 0);
         bit po = ($urandom_range(0, 3) == 0);
         cyc(r, p, byte'($urandom), po, c);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
